// File: rtl/dbus_demux_pkg.sv
// Shared definitions for the data-bus demultiplexer:
// default memory map, timeout and FSM state encoding.
package dbus_demux_pkg;

    localparam logic [31:0] DMEM_BASE = 32'h0000_0000;
    localparam logic [31:0] DMEM_MASK = 32'hF000_0000;
    localparam logic [31:0] MMIO_BASE = 32'h1000_0000;
    localparam logic [31:0] MMIO_MASK = 32'hF000_0000;

    localparam int DBUS_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } state_t;

endpackage

// File: rtl/dbus_addr_decode.sv
// Combinational address decode for the data-bus demux.
// Port 1 wins when both windows match.
module dbus_addr_decode
    import dbus_demux_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DMEM_BASE,
    parameter logic [31:0] S0_MASK = DMEM_MASK,
    parameter logic [31:0] S1_BASE = MMIO_BASE,
    parameter logic [31:0] S1_MASK = MMIO_MASK
) (
    input  logic [31:0] addr,
    output logic        sel0,
    output logic        sel1,
    output logic        unmapped
);

    assign sel1     = (addr & S1_MASK) == S1_BASE;
    assign sel0     = !sel1 && ((addr & S0_MASK) == S0_BASE);
    assign unmapped = !sel0 && !sel1;

endmodule

// File: rtl/dbus_demux.sv
// 1-to-2 data-bus router: memory on port 0, MMIO on port 1,
// one outstanding transaction, local error for unmapped/timeout.
module dbus_demux
    import dbus_demux_pkg::*;
#(
    parameter logic [31:0] S0_BASE = DMEM_BASE,
    parameter logic [31:0] S0_MASK = DMEM_MASK,
    parameter logic [31:0] S1_BASE = MMIO_BASE,
    parameter logic [31:0] S1_MASK = MMIO_MASK,
    parameter int          TIMEOUT = DBUS_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        m0_req_valid,
    input  logic        m0_req_ready,
    output logic [31:0] m0_addr,
    output logic        m0_we,
    output logic [31:0] m0_wdata,
    output logic [3:0]  m0_wstrb,
    input  logic        m0_resp_valid,
    input  logic [31:0] m0_resp_rdata,
    output logic        m1_req_valid,
    input  logic        m1_req_ready,
    output logic [31:0] m1_addr,
    output logic        m1_we,
    output logic [31:0] m1_wdata,
    output logic [3:0]  m1_wstrb,
    input  logic        m1_resp_valid,
    input  logic [31:0] m1_resp_rdata
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TL = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TLAST = CW'(TL);
    localparam logic [CW-1:0] CMAX  = {CW{1'b1}};

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic          cur_sel;
    logic          cur_we;

    logic          sel0;
    logic          sel1;
    logic          unmapped;
    logic          accept;
    logic          fire;
    logic          err_n;
    logic [31:0]   rdata_n;
    logic          sel_rvalid;
    logic [31:0]   sel_rdata;

    dbus_addr_decode #(
        .S0_BASE (S0_BASE),
        .S0_MASK (S0_MASK),
        .S1_BASE (S1_BASE),
        .S1_MASK (S1_MASK)
    ) u_dec (
        .addr     (req_addr),
        .sel0     (sel0),
        .sel1     (sel1),
        .unmapped (unmapped)
    );

    assign m0_addr  = req_addr;
    assign m0_we    = req_we;
    assign m0_wdata = req_wdata;
    assign m0_wstrb = req_wstrb;
    assign m1_addr  = req_addr;
    assign m1_we    = req_we;
    assign m1_wdata = req_wdata;
    assign m1_wstrb = req_wstrb;

    // only the selected target's response is ever looked at
    assign sel_rvalid = cur_sel ? m1_resp_valid : m0_resp_valid;
    assign sel_rdata  = cur_sel ? m1_resp_rdata : m0_resp_rdata;

    always_comb begin
        state_n      = state;
        req_ready    = 1'b0;
        m0_req_valid = 1'b0;
        m1_req_valid = 1'b0;
        accept       = 1'b0;
        fire         = 1'b0;
        err_n        = 1'b0;
        rdata_n      = '0;
        unique case (state)
            IDLE: begin
                m0_req_valid = req_valid & sel0;
                m1_req_valid = req_valid & sel1;
                req_ready    = sel0 ? m0_req_ready :
                               sel1 ? m1_req_ready : 1'b1;
                accept       = req_valid & req_ready;
                if (accept) begin
                    state_n = unmapped ? ERR : WAIT;
                end
            end
            WAIT: begin
                if (sel_rvalid) begin
                    fire    = 1'b1;
                    rdata_n = cur_we ? 32'h0 : sel_rdata;
                    state_n = IDLE;
                end else if ((TIMEOUT != 0) && (cnt == TLAST)) begin
                    fire    = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end
            ERR: begin
                fire    = 1'b1;
                err_n   = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            cur_sel    <= 1'b0;
            cur_we     <= 1'b0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            state      <= state_n;
            resp_valid <= fire;
            resp_err   <= err_n;
            resp_rdata <= rdata_n;
            if (accept && !unmapped) begin
                cur_sel <= sel1;
                cur_we  <= req_we;
                cnt     <= '0;
            end else if (state == WAIT && cnt != CMAX) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/dbus_demux.md
Name: dbus_demux

Overview:
- 1-to-2 data-bus request router between the core's load/store unit and two targets: port 0 (data memory) and port 1 (MMIO peripherals).
- Decodes each request address and forwards the request to the matching target.
- Tracks one outstanding transaction and returns the target's response to the core.
- Unmapped addresses and response timeouts are answered locally with an error response.

Parameters:
- S0_BASE, 32'h0000_0000, port-0 match value after masking.
- S0_MASK, 32'hF000_0000, port-0 address mask.
- S1_BASE, 32'h1000_0000, port-1 match value after masking.
- S1_MASK, 32'hF000_0000, port-1 address mask.
- TIMEOUT, 64, cycles in WAIT before a local error response; 0 disables the timeout.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  core request valid.
- req_ready  out  1  core request accepted this cycle (when high together with req_valid).
- req_addr  in  32  byte address.
- req_we  in  1  1 = store, 0 = load.
- req_wdata  in  32  store data.
- req_wstrb  in  4  byte enables.
- resp_valid  out  1  one-cycle response pulse to the core.
- resp_rdata  out  32  load data; 0 for stores and errors.
- resp_err  out  1  error flag, qualified by resp_valid.
- mN_req_valid  out  1  request valid to target N (N = 0, 1).
- mN_req_ready  in  1  target N accepts the request.
- mN_addr / mN_we / mN_wdata / mN_wstrb  out  32/1/32/4  request fields to target N; combinational copies of req_*.
- mN_resp_valid  in  1  target N response or write acknowledge.
- mN_resp_rdata  in  32  target N read data.

Behaviour:
- Decode (combinational): sel1 = (req_addr & S1_MASK) == S1_BASE; sel0 = !sel1 && (req_addr & S0_MASK) == S0_BASE; unmapped = !sel0 && !sel1. Port 1 wins an overlap.
- FSM states: IDLE, WAIT, ERR. Reset forces IDLE, resp_valid = 0, resp_err = 0, resp_rdata = 0, counter = 0, cur_sel = 0.
- IDLE:
  - m0_req_valid = req_valid & sel0; m1_req_valid = req_valid & sel1.
  - req_ready = sel0 ? m0_req_ready : sel1 ? m1_req_ready : 1.
  - On accept (req_valid & req_ready): mapped → register cur_sel, go WAIT, clear counter; unmapped → go ERR.
- WAIT:
  - req_ready = 0; both mN_req_valid = 0.
  - When m[cur_sel]_resp_valid = 1 in cycle N: in cycle N+1 resp_valid = 1, resp_rdata = registered m[cur_sel]_resp_rdata (forced to 0 if the transaction was a store), resp_err = 0; state → IDLE.
  - Otherwise the counter increments. When TIMEOUT != 0 and the counter reaches TIMEOUT-1 with no response: next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0; state → IDLE.
  - A target response and the timeout in the same cycle: the response wins (resp_err = 0).
- ERR: next cycle resp_valid = 1, resp_err = 1, resp_rdata = 0; state → IDLE.
- resp_valid is high for exactly one cycle; the core has no response backpressure.
- A new request may be accepted in the same cycle that resp_valid is high. Back-to-back throughput is therefore 1 transaction per (target latency + 1) cycles.
- Responses are discarded, with no state change, when they arrive:
  - from the non-selected target;
  - while in IDLE or ERR;
  - after a timeout.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0; a late target response after reset release is ignored.
- Request fields are not registered; the core holds them stable while req_valid is high and unaccepted.

Decomposition:
- Shared package: default memory-map constants (DMEM_BASE/MASK, MMIO_BASE/MASK), the state enum {IDLE, WAIT, ERR}, and DBUS_TIMEOUT_DEFAULT.
- One natural sub-module: dbus_addr_decode, purely combinational (addr → sel0, sel1, unmapped). The FSM, counter and response registers stay in the top module.

Test Plan:
- Load to 32'h0000_0010, m0 ready immediately, m0_resp_valid two cycles later with rdata 32'hCAFE_F00D → resp_valid one cycle after that, resp_rdata = 32'hCAFE_F00D, resp_err = 0; m1_req_valid never high.
- Store to 32'h1000_0004 with wstrb 4'b0011 and m1_req_ready held low for 3 cycles → req_ready low for those 3 cycles, m1 fields equal req_*, single accept; the ack returns resp_rdata = 0, resp_err = 0.
- Load to 32'h2000_0000 (unmapped) → accepted the same cycle, resp_valid two cycles later with resp_err = 1 and resp_rdata = 0; no mN_req_valid asserted.
- TIMEOUT = 8, m0 never responds → resp_err = 1 pulse 9 cycles after accept; a late m0_resp_valid is ignored with no second resp_valid. Repeat with the response landing on the timeout cycle → resp_err = 0 with the target data.
- Back-to-back loads alternating m0/m1, each target responding in 1 cycle → new accept in every cycle where resp_valid is high; data returns in order; a spurious m1_resp_valid during an m0 WAIT is ignored.
- rst_n pulsed low while in WAIT → outputs 0 immediately (asynchronous); a target response after release produces no resp_valid; the next request completes normally.
